// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller:
// forward select encodings and sequencer states.
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] FWD_REG     = 2'd0;
    localparam logic [1:0] FWD_ALU_MEM = 2'd1;
    localparam logic [1:0] FWD_MEM_DIN = 2'd2;
    localparam logic [1:0] FWD_WB      = 2'd3;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Combinational EXE operand forward select for one source register.
// MEM stage beats WB stage; $0 never forwards.
module fwd_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] addr_exe,
    input  logic [4:0] regw_addr_mem,
    input  logic       wb_wen_mem,
    input  logic       mem_ren_mem,
    input  logic [4:0] regw_addr_wb,
    input  logic       wb_wen_wb,
    output logic [1:0] fwd_sel
);

    logic hit_mem;
    logic hit_wb;

    assign hit_mem = wb_wen_mem && (regw_addr_mem != 5'd0)
                     && (regw_addr_mem == addr_exe);
    assign hit_wb  = wb_wen_wb && (regw_addr_wb != 5'd0)
                     && (regw_addr_wb == addr_exe);

    always_comb begin
        fwd_sel = FWD_REG;
        if (hit_mem)
            fwd_sel = mem_ren_mem ? FWD_MEM_DIN : FWD_ALU_MEM;
        else if (hit_wb)
            fwd_sel = FWD_WB;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: boot hold, memory stalls, branch flush,
// operand forwarding and performance counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int RST_HOLD    = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             is_branch_mem,
    input  logic [4:0]       regw_addr_mem,
    input  logic             wb_wen_mem,
    input  logic             mem_ren_mem,
    input  logic             mem_wen_mem,
    input  logic [4:0]       regw_addr_wb,
    input  logic             wb_wen_wb,
    input  logic [4:0]       addr_rs_exe,
    input  logic [4:0]       addr_rt_exe,
    input  logic             dmem_ack,
    output logic             if_rst,
    output logic             id_rst,
    output logic             exe_rst,
    output logic             mem_rst,
    output logic             wb_rst,
    output logic             if_en,
    output logic             id_en,
    output logic             exe_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic [1:0]       exe_fwd_a_ctrl,
    output logic [1:0]       exe_fwd_b_ctrl,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int BW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    hz_state_e   state;
    logic [BW-1:0] boot_cnt;
    logic [WW-1:0] wait_cnt;
    logic          booting;
    logic          mem_access;
    logic          force_release;
    logic          stall;
    logic          flush;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;

    assign booting       = (state == BOOT);
    assign mem_access    = mem_ren_mem | mem_wen_mem;
    assign force_release = !booting && mem_access
                           && (wait_cnt == WW'(MEM_TIMEOUT - 1));
    assign stall         = !booting && mem_access && !dmem_ack
                           && !force_release;
    assign flush         = (state == RUN) && !stall && is_branch_mem;

    fwd_unit u_fwd_a (
        .addr_exe      (addr_rs_exe),
        .regw_addr_mem (regw_addr_mem),
        .wb_wen_mem    (wb_wen_mem),
        .mem_ren_mem   (mem_ren_mem),
        .regw_addr_wb  (regw_addr_wb),
        .wb_wen_wb     (wb_wen_wb),
        .fwd_sel       (fwd_a)
    );

    fwd_unit u_fwd_b (
        .addr_exe      (addr_rt_exe),
        .regw_addr_mem (regw_addr_mem),
        .wb_wen_mem    (wb_wen_mem),
        .mem_ren_mem   (mem_ren_mem),
        .regw_addr_wb  (regw_addr_wb),
        .wb_wen_wb     (wb_wen_wb),
        .fwd_sel       (fwd_b)
    );

    assign exe_fwd_a_ctrl = booting ? FWD_REG : fwd_a;
    assign exe_fwd_b_ctrl = booting ? FWD_REG : fwd_b;

    always_comb begin
        if_rst  = booting;
        id_rst  = booting || flush;
        exe_rst = booting || flush;
        mem_rst = booting || flush;
        wb_rst  = booting || stall;
        if_en   = !booting && !stall;
        id_en   = !booting && !stall;
        exe_en  = !booting && !stall;
        mem_en  = !booting && !stall;
        wb_en   = !booting;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= BOOT;
            boot_cnt        <= '0;
            wait_cnt        <= '0;
            mem_timeout_err <= 1'b0;
            cycle_cnt       <= '0;
            stall_cnt       <= '0;
            flush_cnt       <= '0;
        end else begin
            case (state)
                BOOT: begin
                    if (boot_cnt == BW'(RST_HOLD - 1)) begin
                        state    <= RUN;
                        boot_cnt <= '0;
                    end else begin
                        boot_cnt <= boot_cnt + BW'(1);
                    end
                end
                RUN, MEM_WAIT: begin
                    cycle_cnt <= cycle_cnt + CNT_W'(1);
                    if (stall) begin
                        state     <= MEM_WAIT;
                        wait_cnt  <= wait_cnt + WW'(1);
                        stall_cnt <= stall_cnt + CNT_W'(1);
                    end else begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end
                    if (flush)
                        flush_cnt <= flush_cnt + CNT_W'(1);
                    if (force_release)
                        mem_timeout_err <= 1'b1;
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule
